seq_detect_param: RTL and testbench

- Parametrised serial pattern detector. Successor to the fixed 4-bit overlap/non-overlap Mealy detector.
- Detects a runtime-programmable PAT_W-bit pattern on a 1-bit stream qualified by a valid strobe.
- Overlap or non-overlap mode is selected per bit.
- Provides a combinational Mealy match, a registered match pulse and a saturating match counter for status readout.

---
 rtl/seq_detect_param.sv | 80 ++++++++
 tb/tb_seq_detect_param.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Serial pattern detector: programmable PAT_W-bit pattern, per-bit overlap mode, saturating match counter.
// Define SEQ_DET_MASK_EN to add per-position don't-care masking (pat_mask_in / mask ports).
module seq_detect_param #(
    parameter int unsigned     PAT_W   = 4,
    parameter int unsigned     CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(4'b1010)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             din,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
`ifdef SEQ_DET_MASK_EN
    input  logic [PAT_W-1:0] pat_mask_in,
    output logic [PAT_W-1:0] mask,
`endif
    output logic             match,
    output logic             match_q,
    output logic [CNT_W-1:0] match_cnt,
    output logic [PAT_W-1:0] pattern
);

    localparam int unsigned     FW       = $clog2(PAT_W);
    localparam logic [FW-1:0]   FILL_MAX = FW'(PAT_W - 1);

    logic [PAT_W-2:0] history;
    logic [FW-1:0]    fill;
    logic [PAT_W-1:0] cand;
    logic             hit;

    always_comb begin
        cand = {history, din};
`ifdef SEQ_DET_MASK_EN
        hit  = ((cand ^ pattern) & ~mask) == '0;
`else
        hit  = (cand == pattern);
`endif
        match = in_valid & ~pat_load & ~rst & (fill == FILL_MAX) & hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            history   <= '0;
            fill      <= '0;
            pattern   <= RST_PAT;
            match_q   <= 1'b0;
            match_cnt <= '0;
`ifdef SEQ_DET_MASK_EN
            mask      <= '0;
`endif
        end else begin
            match_q <= match;

            if (cnt_clr)
                match_cnt <= '0;
            else if (match && (match_cnt != '1))
                match_cnt <= match_cnt + CNT_W'(1);

            if (pat_load) begin
                pattern <= pat_in;
`ifdef SEQ_DET_MASK_EN
                mask    <= pat_mask_in;
`endif
                history <= '0;
                fill    <= '0;
            end else if (in_valid) begin
                history <= cand[PAT_W-2:0];
                // non-overlap restarts the fill so old bits cannot seed the next match
                if (match && !overlap)
                    fill <= '0;
                else if (fill != FILL_MAX)
                    fill <= fill + FW'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param (PAT_W=4); a CNT_W=2 twin shares the stimulus for saturation.
// Mask scenario runs only when SEQ_DET_MASK_EN is defined.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst, in_valid, din, overlap, pat_load, cnt_clr;
    logic [3:0] pat_in;
    logic       match, match_q, match_b, match_q_b;
    logic [7:0] match_cnt;
    logic [1:0] cnt_sat;
    logic [3:0] pattern, pattern_b;
`ifdef SEQ_DET_MASK_EN
    logic [3:0] pat_mask_in = '0;
    logic [3:0] mask, mask_b;
`endif

    typedef struct packed {
        logic       m;
        logic [7:0] c8;
        logic [1:0] c2;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [7:0] mc8 = '0;
    logic [1:0] mc2 = '0;
    int         nvec = 0;
    int         nerr = 0;

    always #5 clk = ~clk;

    seq_detect_param #(.PAT_W(4), .CNT_W(8), .RST_PAT(4'b1010)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .din(din), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
`ifdef SEQ_DET_MASK_EN
        .pat_mask_in(pat_mask_in), .mask(mask),
`endif
        .match(match), .match_q(match_q), .match_cnt(match_cnt), .pattern(pattern)
    );

    seq_detect_param #(.PAT_W(4), .CNT_W(2), .RST_PAT(4'b1010)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .din(din), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
`ifdef SEQ_DET_MASK_EN
        .pat_mask_in(pat_mask_in), .mask(mask_b),
`endif
        .match(match_b), .match_q(match_q_b), .match_cnt(cnt_sat), .pattern(pattern_b)
    );

    // Drive one cycle on the falling edge and queue what both DUTs should show.
    task automatic drive(input logic v, input logic d, input logic ov, input logic pl,
                         input logic [3:0] pi, input logic cc, input logic r, input logic em);
        exp_t x;
        @(negedge clk);
        rst = r; in_valid = v; din = d; overlap = ov; pat_load = pl; pat_in = pi; cnt_clr = cc;
        if (r || cc) begin
            mc8 = '0;
            mc2 = '0;
        end else if (em) begin
            if (mc8 != 8'hFF) mc8 = mc8 + 8'd1;
            if (mc2 != 2'b11) mc2 = mc2 + 2'd1;
        end
        x.m = em; x.c8 = mc8; x.c2 = mc2;
        sb.push_back(x);
    endtask

    task automatic apply_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        e = sb.pop_front();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
            #1 e = sb.pop_front();
            nvec++; if (match !== e.m) begin nerr++; $display("FAIL rst_match got %b exp %b", match, e.m); end
            @(posedge clk); #1;
            nvec++; if (match_q !== e.m) begin nerr++; $display("FAIL rst_match_q got %b exp %b", match_q, e.m); end
            nvec++; if (match_cnt !== e.c8) begin nerr++; $display("FAIL rst_cnt got %0d exp %0d", match_cnt, e.c8); end
            nvec++; if (pattern !== 4'b1010) begin nerr++; $display("FAIL rst_pattern got %b exp 1010", pattern); end
        end
    endtask

    // Shared body for the two 8-bit 1010... streams; ov selects mode, ex lists expected match in time order.
    task automatic run_stream(input string name, input logic ov, input logic [7:0] ex);
        logic [7:0] bits;
        bits = 8'b10101010;
        apply_reset();
        for (int i = 7; i >= 0; i--) begin
            drive(1'b1, bits[i], ov, 1'b0, 4'b0000, 1'b0, 1'b0, ex[i]);
            #1 e = sb.pop_front();
            nvec++; if (match !== e.m) begin nerr++; $display("FAIL %s_match[%0d] got %b exp %b", name, 7-i, match, e.m); end
            @(posedge clk); #1;
            nvec++; if (match_q !== e.m) begin nerr++; $display("FAIL %s_match_q[%0d] got %b exp %b", name, 7-i, match_q, e.m); end
            nvec++; if (match_cnt !== e.c8) begin nerr++; $display("FAIL %s_cnt[%0d] got %0d exp %0d", name, 7-i, match_cnt, e.c8); end
        end
    endtask

    task automatic test_overlap();
        run_stream("ovl", 1'b1, 8'b00010101);
        nvec++; if (match_cnt !== 8'd3) begin nerr++; $display("FAIL ovl_total got %0d exp 3", match_cnt); end
    endtask

    task automatic test_non_overlap();
        run_stream("novl", 1'b0, 8'b00010001);
        nvec++; if (match_cnt !== 8'd2) begin nerr++; $display("FAIL novl_total got %0d exp 2", match_cnt); end
    endtask

    task automatic test_valid_gap();
        logic [6:0] v, d, ex;
        v = 7'b1110001; d = 7'b1010000; ex = 7'b0000001;
        apply_reset();
        for (int i = 6; i >= 0; i--) begin
            drive(v[i], d[i], 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, ex[i]);
            #1 e = sb.pop_front();
            nvec++; if (match !== e.m) begin nerr++; $display("FAIL gap_match[%0d] got %b exp %b", 6-i, match, e.m); end
            @(posedge clk); #1;
            nvec++; if (match_q !== e.m) begin nerr++; $display("FAIL gap_match_q[%0d] got %b exp %b", 6-i, match_q, e.m); end
            nvec++; if (match_cnt !== e.c8) begin nerr++; $display("FAIL gap_cnt[%0d] got %0d exp %0d", 6-i, match_cnt, e.c8); end
        end
    endtask

    task automatic test_pat_load();
        // 0,1,1 then load (with a discarded 0), then 0,1,1,0
        logic [7:0] d, pl, ex;
        d  = 8'b01100110; pl = 8'b00010000; ex = 8'b00000001;
        apply_reset();
        for (int i = 7; i >= 0; i--) begin
            drive(1'b1, d[i], 1'b1, pl[i], 4'b0110, 1'b0, 1'b0, ex[i]);
            #1 e = sb.pop_front();
            nvec++; if (match !== e.m) begin nerr++; $display("FAIL load_match[%0d] got %b exp %b", 7-i, match, e.m); end
            @(posedge clk); #1;
            nvec++; if (match_q !== e.m) begin nerr++; $display("FAIL load_match_q[%0d] got %b exp %b", 7-i, match_q, e.m); end
            nvec++; if (match_cnt !== e.c8) begin nerr++; $display("FAIL load_cnt[%0d] got %0d exp %0d", 7-i, match_cnt, e.c8); end
        end
        nvec++; if (pattern !== 4'b0110) begin nerr++; $display("FAIL load_pattern got %b exp 0110", pattern); end
    endtask

    task automatic test_saturate();
        // load 1111, eight ones, then one more matching one with cnt_clr
        logic [9:0] pl, cc, ex;
        pl = 10'b1000000000; cc = 10'b0000000001; ex = 10'b0000111111;
        apply_reset();
        for (int i = 9; i >= 0; i--) begin
            drive(1'b1, 1'b1, 1'b1, pl[i], 4'b1111, cc[i], 1'b0, ex[i]);
            #1 e = sb.pop_front();
            nvec++; if (match_b !== e.m) begin nerr++; $display("FAIL sat_match[%0d] got %b exp %b", 9-i, match_b, e.m); end
            @(posedge clk); #1;
            nvec++; if (cnt_sat !== e.c2) begin nerr++; $display("FAIL sat_cnt2[%0d] got %0d exp %0d", 9-i, cnt_sat, e.c2); end
            nvec++; if (match_cnt !== e.c8) begin nerr++; $display("FAIL sat_cnt8[%0d] got %0d exp %0d", 9-i, match_cnt, e.c8); end
        end
    endtask

`ifdef SEQ_DET_MASK_EN
    task automatic test_mask();
        // load 1010/0001, stream 1,0,1,0,1,1,1,0 then reset mid-pattern
        logic [9:0] d, pl, r, ex;
        d  = 10'b0101011100; pl = 10'b1000000000; r = 10'b0000000001; ex = 10'b0000101000;
        apply_reset();
        pat_mask_in = 4'b0001;
        for (int i = 9; i >= 0; i--) begin
            drive(1'b1, d[i], 1'b1, pl[i], 4'b1010, 1'b0, r[i], ex[i]);
            #1 e = sb.pop_front();
            nvec++; if (match !== e.m) begin nerr++; $display("FAIL mask_match[%0d] got %b exp %b", 9-i, match, e.m); end
            @(posedge clk); #1;
            nvec++; if (match_q !== e.m) begin nerr++; $display("FAIL mask_match_q[%0d] got %b exp %b", 9-i, match_q, e.m); end
            nvec++; if (match_cnt !== e.c8) begin nerr++; $display("FAIL mask_cnt[%0d] got %0d exp %0d", 9-i, match_cnt, e.c8); end
            if (i == 9) begin
                nvec++; if (mask !== 4'b0001) begin nerr++; $display("FAIL mask_loaded got %b exp 0001", mask); end
            end
        end
        nvec++; if (mask !== 4'b0000) begin nerr++; $display("FAIL mask_rst got %b exp 0000", mask); end
        nvec++; if (pattern !== 4'b1010) begin nerr++; $display("FAIL mask_rst_pattern got %b exp 1010", pattern); end
        pat_mask_in = 4'b0000;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; din = 1'b0; overlap = 1'b1;
        pat_load = 1'b0; pat_in = 4'b0000; cnt_clr = 1'b0;
        test_reset();
        test_overlap();
        test_non_overlap();
        test_valid_gap();
        test_pat_load();
        test_saturate();
`ifdef SEQ_DET_MASK_EN
        test_mask();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
